// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage: EX/MEM register with 2-entry skid buffer, flush and bubble masking (upstream i_valid/o_ready/i_data/i_ctrl, downstream o_valid/i_ready/o_data/o_ctrl, i_flush, o_count)
module ex_mem_pipe_stage #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 4,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_count
);
  logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              up, dn;
  assign o_ready = ~s_valid_q;
  assign o_valid = m_valid_q;
  assign o_data  = m_data_q;
  assign o_ctrl  = m_valid_q ? m_ctrl_q : '0;
  assign o_count = cnt_q;
  assign up = i_valid & ~s_valid_q;
  assign dn = m_valid_q & i_ready;
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    if (i_flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      if (CLEAR_DATA) begin
        m_data_d = '0;
        m_ctrl_d = '0;
        s_data_d = '0;
        s_ctrl_d = '0;
      end
    end else if (s_valid_q) begin
      if (dn) begin
        m_data_d  = s_data_q;
        m_ctrl_d  = s_ctrl_q;
        s_valid_d = 1'b0;
      end
    end else if (m_valid_q) begin
      if (up && dn) begin
        m_data_d = i_data;
        m_ctrl_d = i_ctrl;
      end else if (dn) begin
        m_valid_d = 1'b0;
      end else if (up) begin
        s_valid_d = 1'b1;
        s_data_d  = i_data;
        s_ctrl_d  = i_ctrl;
      end
    end else if (up) begin
      m_valid_d = 1'b1;
      m_data_d  = i_data;
      m_ctrl_d  = i_ctrl;
    end
    cnt_d = {s_valid_d, m_valid_d & ~s_valid_d};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= '0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// tb_ex_mem_pipe_stage: directed scenarios plus a FIFO scoreboard checking order, count and bubble masking
module tb_ex_mem_pipe_stage;
  localparam int DW = 102;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst, i_valid, i_ready, i_flush;
  logic [DW-1:0] i_data;
  logic [CW-1:0] i_ctrl;
  logic          o_ready, o_valid;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_ctrl;
  logic [1:0]    o_count;
  logic [DW+CW-1:0] q[$];
  logic [DW+CW-1:0] exp_e;
  int checks = 0, passes = 0;
  bit mon_en = 1'b0;
  ex_mem_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_ctrl(i_ctrl), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_ctrl(o_ctrl), .o_count(o_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (mon_en) begin
    checks++;
    if (o_count !== 2'(q.size())) $display("FAIL sb_count: got %0d want %0d", o_count, q.size());
    else passes++;
    checks++;
    if (o_ready !== (q.size() < 2)) $display("FAIL sb_ready: got %b want %b", o_ready, q.size() < 2);
    else passes++;
    checks++;
    if (o_valid !== (q.size() != 0)) $display("FAIL sb_valid: got %b want %b", o_valid, q.size() != 0);
    else passes++;
    if (o_valid === 1'b0) begin
      checks++;
      if (o_ctrl !== '0) $display("FAIL sb_bubble_ctrl: got %h want 0", o_ctrl);
      else passes++;
    end
    if (o_valid && i_ready && q.size() != 0) begin
      exp_e = q.pop_front();
      checks++;
      if ({o_ctrl, o_data} !== exp_e) $display("FAIL sb_data: got %h/%h want %h/%h", o_ctrl, o_data, exp_e[DW+CW-1:DW], exp_e[DW-1:0]);
      else passes++;
    end
    if (rst || i_flush) q.delete();
    else if (i_valid && o_ready) q.push_back({i_ctrl, i_data});
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0; i_data = '0; i_ctrl = '0;
    repeat (2) tick;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else passes++;
    checks++; if (o_ctrl !== '0) $display("FAIL reset_ctrl: got %h want 0", o_ctrl); else passes++;
    checks++; if (o_data !== '0) $display("FAIL reset_data: got %h want 0", o_data); else passes++;
    checks++; if (o_count !== 2'd0) $display("FAIL reset_count: got %0d want 0", o_count); else passes++;
    checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_ready); else passes++;
  endtask
  task automatic test_stream;
    i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      i_valid = 1'b1; i_data = DW'(i); i_ctrl = CW'(i);
      tick;
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_data !== DW'(i) || o_count !== 2'd1)
        $display("FAIL stream_%0d: got v=%b d=%h c=%0d want v=1 d=%h c=1", i, o_valid, o_data, o_count, i);
      else passes++;
    end
    i_valid = 1'b0;
    tick;
  endtask
  task automatic test_back_pressure;
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = DW'('h10); i_ctrl = 4'h1; tick;
    i_data = DW'('h20); i_ctrl = 4'h2; tick;
    i_data = DW'('h30); i_ctrl = 4'h3;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (o_count !== 2'd2 || o_ready !== 1'b0 || o_data !== DW'('h10))
        $display("FAIL bp_full_%0d: got c=%0d r=%b d=%h want c=2 r=0 d=10", k, o_count, o_ready, o_data);
      else passes++;
      tick;
    end
    i_ready = 1'b1;
    tick;
    @(negedge clk);
    checks++;
    if (o_data !== DW'('h20) || o_ready !== 1'b1 || o_count !== 2'd1)
      $display("FAIL bp_second: got d=%h r=%b c=%0d want d=20 r=1 c=1", o_data, o_ready, o_count);
    else passes++;
    tick;
    i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_data !== DW'('h30) || o_valid !== 1'b1)
      $display("FAIL bp_third: got d=%h v=%b want d=30 v=1", o_data, o_valid);
    else passes++;
    tick;
  endtask
  task automatic test_flush;
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = DW'('h40); i_ctrl = 4'hA; tick;
    i_data = DW'('h50); i_ctrl = 4'hB; tick;
    i_data = DW'('h60); i_ctrl = 4'hC; i_flush = 1'b1; tick;
    i_flush = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ctrl !== '0 || o_count !== 2'd0 || o_ready !== 1'b1)
      $display("FAIL flush_state: got v=%b ctl=%h c=%0d r=%b want v=0 ctl=0 c=0 r=1", o_valid, o_ctrl, o_count, o_ready);
    else passes++;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0) $display("FAIL flush_ghost_%0d: got v=%b want 0", k, o_valid);
      else passes++;
    end
  endtask
  task automatic test_bubble;
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = DW'('h70); i_ctrl = 4'hF; tick;
    i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_ctrl !== 4'hF) $display("FAIL bubble_held: got v=%b ctl=%h want v=1 ctl=f", o_valid, o_ctrl);
    else passes++;
    i_ready = 1'b1; tick;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ctrl !== 4'h0) $display("FAIL bubble_masked: got v=%b ctl=%h want v=0 ctl=0", o_valid, o_ctrl);
    else passes++;
  endtask
  task automatic test_reset_mid;
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = DW'('h80); i_ctrl = 4'h5; tick;
    i_data = DW'('h90); i_ctrl = 4'h6; tick;
    @(negedge clk);
    checks++;
    if (o_count !== 2'd2) $display("FAIL rstmid_fill: got c=%0d want 2", o_count);
    else passes++;
    rst = 1'b1; i_flush = 1'b1; i_data = DW'('hA0); tick;
    rst = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ctrl !== '0 || o_data !== '0 || o_count !== 2'd0 || o_ready !== 1'b1)
      $display("FAIL rstmid_state: got v=%b ctl=%h d=%h c=%0d r=%b want all reset", o_valid, o_ctrl, o_data, o_count, o_ready);
    else passes++;
  endtask
  task automatic test_random;
    for (int k = 0; k < 300; k++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 29) == 0);
      i_data  = {$urandom, $urandom, $urandom, $urandom};
      i_ctrl  = CW'($urandom);
      tick;
    end
    i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    repeat (3) tick;
    @(negedge clk);
    checks++;
    if (q.size() != 0 || o_valid !== 1'b0) $display("FAIL random_drain: got left=%0d v=%b want 0/0", q.size(), o_valid);
    else passes++;
  endtask
  initial begin
    test_reset;
    test_stream;
    test_back_pressure;
    test_flush;
    test_bubble;
    test_reset_mid;
    test_random;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
